// File: rtl/enc8to3_seq_if.sv
// Request/code handshake bundle for enc8to3_seq.
// The slave modport is the encoder side; the master modport is the vector producer and code consumer.
interface enc8to3_seq_if;
  logic [7:0] req;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       code_last;
  logic       zero_flag;

  modport master (
    output req, req_valid, code_ready,
    input  req_ready, code, code_valid, code_last, zero_flag
  );

  modport slave (
    input  req, req_valid, code_ready,
    output req_ready, code, code_valid, code_last, zero_flag
  );
endinterface

// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector and emits one binary code per set bit.
// Scan order is lowest-index-first by default; define ENC_ROUND_ROBIN_EN for a round-robin pointer.
module enc8to3_seq (
  input  logic          clk,
  input  logic          reset,
  enc8to3_seq_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] pending;
  logic [2:0] code_r;
  logic       last_r;
  logic       zflag_r;
  logic       accept;
  logic       take;
  logic [7:0] remain;
  logic [7:0] scan_src;
  logic [2:0] pick_code;

  function automatic logic single_bit(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] ptr;

  // First set bit found walking upward from after+1, wrapping 7->0.
  function automatic logic [2:0] scan_rr(input logic [7:0] v, input logic [2:0] after);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = after + 3'(k);
      if (!found && v[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction
`else
  function automatic logic [2:0] scan_low(input logic [7:0] v);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) res = 3'(i);
    end
    return res;
  endfunction
`endif

  assign accept   = (state == IDLE) && bus.req_valid;
  assign take     = (state == EMIT) && bus.code_ready;
  assign remain   = pending & ~(8'd1 << code_r);
  assign scan_src = (state == IDLE) ? bus.req : remain;

  // In EMIT the pointer is about to become code_r, so the search continues after it.
`ifdef ENC_ROUND_ROBIN_EN
  assign pick_code = scan_rr(scan_src, (state == IDLE) ? ptr : code_r);
`else
  assign pick_code = scan_low(scan_src);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (bus.req != 8'd0)) state_nxt = EMIT;
      EMIT:    if (take && last_r)              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.code_valid = (state == EMIT);
    bus.code       = code_r;
    bus.code_last  = last_r;
    bus.zero_flag  = zflag_r;
  end

  // Code and last flag only move on accept or handshake, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= 8'd0;
      code_r  <= 3'd0;
      last_r  <= 1'b0;
      zflag_r <= 1'b0;
    end else begin
      zflag_r <= accept && (bus.req == 8'd0);
      if (accept) begin
        pending <= bus.req;
        code_r  <= pick_code;
        last_r  <= single_bit(bus.req);
      end else if (take) begin
        pending <= remain;
        if (remain != 8'd0) code_r <= pick_code;
        last_r  <= single_bit(remain);
      end
    end
  end

`ifdef ENC_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!reset)    ptr <= 3'd7;
    else if (take) ptr <= code_r;
  end
`endif

endmodule

// File: tb/tb_enc8to3_seq.sv
// Scoreboard bench for enc8to3_seq: directed scenarios plus random vectors against a code-list model.
// Build with or without ENC_ROUND_ROBIN_EN; the model follows the same macro.
module tb_enc8to3_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enc8to3_seq_if ifc();

  enc8to3_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct packed {
    logic [2:0] code;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] mptr = 3'd7;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected code sequence for one vector, derived from the scan-order rule.
  task automatic model_push(input logic [7:0] v);
    int n;
    int tot;
    int idx;
    n   = 0;
    tot = $countones(v);
    for (int k = 1; k <= 8; k++) begin
`ifdef ENC_ROUND_ROBIN_EN
      idx = (int'(mptr) + k) % 8;
`else
      idx = k - 1;
`endif
      if (v[idx]) begin
        n++;
        exp_q.push_back('{code: 3'(idx), last: (n == tot)});
`ifdef ENC_ROUND_ROBIN_EN
        mptr = 3'(idx);
`endif
      end
    end
  endtask

  task automatic send(input logic [7:0] v, input int hold, input bit rmode, input bit inj);
    int guard;
    int cyc;
    int n;
    n     = $countones(v);
    guard = 0;
    while (!ifc.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_ready_before_send", int'(ifc.req_ready), 1);
    ifc.req        = v;
    ifc.req_valid  = 1'b1;
    ifc.code_ready = (hold == 0);
    model_push(v);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    ifc.req       = 8'($urandom);
    if (v == 8'd0) begin
      check("zero_flag_pulse", int'(ifc.zero_flag), 1);
      check("zero_no_valid", int'(ifc.code_valid), 0);
      check("zero_req_ready", int'(ifc.req_ready), 1);
      @(posedge clk); #1;
      check("zero_flag_drop", int'(ifc.zero_flag), 0);
      check("zero_no_valid_after", int'(ifc.code_valid), 0);
      return;
    end
    check("latency_valid", int'(ifc.code_valid), 1);
    check("req_ready_in_emit", int'(ifc.req_ready), 0);
    check("zero_flag_quiet", int'(ifc.zero_flag), 0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      if (inj && cyc == 0) begin
        ifc.req       = 8'h10;
        ifc.req_valid = 1'b1;
      end else begin
        ifc.req_valid = 1'b0;
      end
      if (cyc < hold)  ifc.code_ready = 1'b0;
      else if (rmode)  ifc.code_ready = 1'($urandom_range(0, 1));
      else             ifc.code_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    ifc.req_valid = 1'b0;
    if (cyc >= 200)  check("drain_timeout", 0, 1);
    else if (!rmode) check("drain_cycles", cyc, n + hold);
    check("req_ready_after", int'(ifc.req_ready), 1);
    check("valid_after", int'(ifc.code_valid), 0);
  endtask

  initial begin
    logic [7:0] v;
    reset          = 1'b0;
    ifc.req        = 8'hFF;
    ifc.req_valid  = 1'b1;
    ifc.code_ready = 1'b1;

    // Monitor: pops the scoreboard on every handshake and checks backpressure stability.
    fork
      begin
        exp_t       e;
        logic       p_rst = 1'b0;
        logic       p_valid = 1'b0;
        logic       p_ready = 1'b0;
        logic [2:0] p_code = 3'd0;
        logic       p_last = 1'b0;
        forever begin
          @(negedge clk);
          if (reset && ifc.code_valid && ifc.code_ready) begin
            if (exp_q.size() == 0) begin
              check("code_without_expectation", int'(ifc.code), -1);
            end else begin
              e = exp_q.pop_front();
              check("code", int'(ifc.code), int'(e.code));
              check("code_last", int'(ifc.code_last), int'(e.last));
            end
          end
          if (reset && p_rst && p_valid && !p_ready) begin
            check("hold_valid", int'(ifc.code_valid), 1);
            check("hold_code", int'(ifc.code), int'(p_code));
            check("hold_last", int'(ifc.code_last), int'(p_last));
          end
          p_rst   = reset;
          p_valid = ifc.code_valid;
          p_ready = ifc.code_ready;
          p_code  = ifc.code;
          p_last  = ifc.code_last;
        end
      end
    join_none

    // Reset with req_valid asserted: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", int'(ifc.req_ready), 1);
    check("rst_code_valid", int'(ifc.code_valid), 0);
    check("rst_code", int'(ifc.code), 0);
    check("rst_code_last", int'(ifc.code_last), 0);
    check("rst_zero_flag", int'(ifc.zero_flag), 0);
    reset         = 1'b1;
    ifc.req_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", int'(ifc.code_valid), 0);

    send(8'b1010_0100, 0, 1'b0, 1'b0);
    send(8'h81, 3, 1'b0, 1'b0);
    send(8'h00, 0, 1'b0, 1'b0);

    // Reset right after the first handshake of an all-ones vector.
    ifc.req        = 8'hFF;
    ifc.req_valid  = 1'b1;
    ifc.code_ready = 1'b1;
    model_push(8'hFF);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    check("ff_valid", int'(ifc.code_valid), 1);
    @(posedge clk); #1;
    check("ff_first_popped", exp_q.size(), 7);
    reset = 1'b0;
    exp_q.delete();
    mptr = 3'd7;
    @(posedge clk); #1;
    check("abort_valid", int'(ifc.code_valid), 0);
    check("abort_req_ready", int'(ifc.req_ready), 1);
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("no_residual", int'(ifc.code_valid), 0);
    end
    check("abort_ready_after", int'(ifc.req_ready), 1);

    send(8'h21, 0, 1'b0, 1'b0);
    send(8'h41, 0, 1'b0, 1'b0);
    send(8'h03, 1, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      send(v, int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)));
    end

    ifc.code_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_idle", int'(ifc.code_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc8to3_seq.md
ENC8TO3_SEQ -- requirements
Module: enc8to3_seq

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-low.
REQ-003 SHALL have req  input  8  one-hot or multi-hot request vector; bit i requests code i.
REQ-004 SHALL have req_valid  input  1  req is presented this cycle.
REQ-005 SHALL have req_ready  output  1  block can accept a new vector (IDLE only).
REQ-006 SHALL have code  output  3  binary index of the bit currently being served.
REQ-007 SHALL have code_valid  output  1  code is valid.
REQ-008 SHALL have code_ready  input  1  consumer accepts code this cycle.
REQ-009 SHALL have code_last  output  1  qualified by code_valid; current code is the final pending bit.
REQ-010 SHALL have zero_flag  output  1  one-cycle pulse; an all-zero vector was accepted.

Function
REQ-011 SHALL implement two states: IDLE (req_ready=1, code_valid=0) and EMIT (req_ready=0, code_valid=1).
REQ-012 SHALL, in IDLE on req_valid&req_ready with req!=0, load req into an 8-bit pending register and enter EMIT; code_valid rises the following cycle (latency 1).
REQ-013 SHALL, in IDLE on req_valid&req_ready with req==0, stay in IDLE and drive zero_flag=1 for exactly the next cycle; no code is emitted.
REQ-014 SHALL ignore req/req_valid while in EMIT.
REQ-015 SHALL drive code, code_valid, code_last from registers; code and code_last SHALL remain stable while code_valid=1 and code_ready=0.
REQ-016 SHALL, on code_valid&code_ready, clear the served bit in pending; if bits remain, present the next code on the next cycle (throughput one code per cycle, no bubble).
REQ-017 SHALL, on handshake with code_last=1, return to IDLE; req_ready=1 and code_valid=0 on the next cycle.
REQ-018 SHALL assert code_last exactly when pending has one bit set.
REQ-019 SHALL select the next code by the scan order of REQ-025/REQ-026; exactly one code per set bit, no duplicates, no omissions.

Reset
REQ-020 SHALL, when reset=0 at a clock edge, clear pending, enter IDLE, and set code=0, code_valid=0, code_last=0, zero_flag=0, req_ready=1 after that edge.
REQ-021 SHALL, on reset mid-EMIT, discard all pending bits; no further codes from the aborted vector.
REQ-022 SHALL set the scan pointer to 7 on reset so the first search starts at index 0.
REQ-023 SHALL take no action on req_valid while reset=0.

Configuration
REQ-024 SHALL use macro ENC_ROUND_ROBIN_EN to select scan order.
REQ-025 SHALL, with ENC_ROUND_ROBIN_EN defined, keep a 3-bit pointer holding the last served index (updated on every code handshake, retained across vectors); search starts at pointer+1, wrapping 7->0.
REQ-026 SHALL, without ENC_ROUND_ROBIN_EN, use fixed priority: lowest set index first; no pointer register is synthesized.

Verification
REQ-027 SHALL cover: after reset, req=8'b1010_0100, code_ready=1 -> codes 2,5,7 on consecutive cycles, code_last only with 7, req_ready=1 the cycle after.
REQ-028 SHALL cover: req=8'h81, code_ready=0 for 3 cycles -> code=0 held valid and stable 3 cycles, then 0 accepted, then 7 with code_last=1.
REQ-029 SHALL cover: req=8'h00 accepted -> zero_flag=1 for one cycle, code_valid stays 0, req_ready stays 1.
REQ-030 SHALL cover: req=8'hFF, reset=0 after first code handshake -> code_valid=0 next cycle, after release req_ready=1 and no residual codes.
REQ-031 SHALL cover: req=8'h21 then req=8'h41 -> first vector 0,5 in both builds; second vector 6,0 with ENC_ROUND_ROBIN_EN, 0,6 without.
REQ-032 SHALL cover: req_valid pulsed with req=8'h10 during EMIT of 8'h03 -> ignored; only codes 0,1 emitted.
